data_memory_sized: RTL and testbench

DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

---
 rtl/data_memory_sized.sv | 205 ++++++++++++++++++++
 tb/tb_data_memory_sized.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// Byte-addressable data memory with sized loads/stores and a one-deep
// registered response stage. Word storage is little-endian; loads are
// sign- or zero-extended; misaligned, illegal-size and out-of-range
// requests are answered with an error response and never touch memory.
module data_memory_sized #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH) + 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = AW - 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Extend a loaded byte to 32 bits.
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
    logic [31:0] r;
    if (uns) begin
      r = {24'h000000, b};
    end else begin
      r = {{24{b[7]}}, b};
    end
    return r;
  endfunction

  // Extend a loaded halfword to 32 bits.
  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
    logic [31:0] r;
    if (uns) begin
      r = {16'h0000, h};
    end else begin
      r = {{16{h[15]}}, h};
    end
    return r;
  endfunction

  // Storage starts at zero; reset never clears it.
  logic [31:0] mem_q [DEPTH] = '{default: 32'h0000_0000};

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q,   rsp_err_d;

  logic          accept_s;
  logic          wr_en_s;
  logic [IW-1:0] idx_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   load_data_s;
  logic [3:0]    be_s;
  logic [31:0]   wlane_s;
  logic          range_err_s;
  logic          align_err_s;
  logic          size_err_s;
  logic          err_s;

  // One response slot: a new request fits when the slot is empty or drains now.
  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept_s  = req_valid && req_ready;

  assign idx_s     = req_addr[AW-1:2];
  assign rd_word_s = mem_q[idx_s];

  // Writes are suppressed while reset is held, even though req_ready reads 1.
  assign wr_en_s = accept_s && req_we && !err_s && rst_n;

  // Classify the request: address range, alignment against size, legal size.
  always_comb begin
    range_err_s = 1'b0;
    align_err_s = 1'b0;
    size_err_s  = 1'b0;
    if ((req_addr >> AW) != 32'h0000_0000) begin
      range_err_s = 1'b1;
    end else begin
      range_err_s = 1'b0;
    end
    case (req_size)
      SZ_BYTE: align_err_s = 1'b0;
      SZ_HALF: align_err_s = req_addr[0];
      SZ_WORD: align_err_s = (req_addr[1:0] != 2'b00);
      default: size_err_s  = 1'b1;
    endcase
    err_s = range_err_s || align_err_s || size_err_s;
  end

  // Pick the addressed byte/half out of the current word and extend it.
  always_comb begin
    load_data_s = 32'h0000_0000;
    case (req_size)
      SZ_BYTE: begin
        case (req_addr[1:0])
          2'b00:   load_data_s = ext_byte(rd_word_s[7:0],   req_unsigned);
          2'b01:   load_data_s = ext_byte(rd_word_s[15:8],  req_unsigned);
          2'b10:   load_data_s = ext_byte(rd_word_s[23:16], req_unsigned);
          2'b11:   load_data_s = ext_byte(rd_word_s[31:24], req_unsigned);
          default: load_data_s = 32'h0000_0000;
        endcase
      end
      SZ_HALF: begin
        if (req_addr[1]) begin
          load_data_s = ext_half(rd_word_s[31:16], req_unsigned);
        end else begin
          load_data_s = ext_half(rd_word_s[15:0], req_unsigned);
        end
      end
      SZ_WORD: load_data_s = rd_word_s;
      default: load_data_s = 32'h0000_0000;
    endcase
  end

  // Replicate right-aligned store data onto every lane and enable the addressed ones.
  always_comb begin
    be_s    = 4'b0000;
    wlane_s = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        wlane_s = {4{req_wdata[7:0]}};
        case (req_addr[1:0])
          2'b00:   be_s = 4'b0001;
          2'b01:   be_s = 4'b0010;
          2'b10:   be_s = 4'b0100;
          2'b11:   be_s = 4'b1000;
          default: be_s = 4'b0000;
        endcase
      end
      SZ_HALF: begin
        wlane_s = {2{req_wdata[15:0]}};
        if (req_addr[1]) begin
          be_s = 4'b1100;
        end else begin
          be_s = 4'b0011;
        end
      end
      SZ_WORD: begin
        wlane_s = req_wdata;
        be_s    = 4'b1111;
      end
      default: begin
        wlane_s = req_wdata;
        be_s    = 4'b0000;
      end
    endcase
  end

  // Next state of the response slot: load on accept, drain on consume, else hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_s;
      if (err_s || req_we) begin
        rsp_rdata_d = 32'h0000_0000;
      end else begin
        rsp_rdata_d = load_data_s;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Response register; reset discards any pending response immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-lane writes into the storage array.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en_s && be_s[b]) begin
        mem_q[idx_s][b*8 +: 8] <= wlane_s[b*8 +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized: table of request vectors with
// expected responses pushed to a scoreboard queue at drive time, plus
// hand-written backpressure, reset and throughput sequences.
module tb_data_memory_sized;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH) + 2;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SX = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_memory_sized #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;
  logic acc_prev = 1'b0;
  int run_len = 0;
  int run_max = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_size = SW; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        e.name = name; e.rdata = exp_rdata; e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: request not accepted within 50 cycles, req_ready=%b expected 1", name, req_ready);
    idle();
  endtask

  // Response monitor: latency check, scoreboard pop, throughput run length.
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_prev) check32("latency_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          check32({mon_e.name, ".rdata"}, rsp_rdata, mon_e.rdata);
          check32({mon_e.name, ".err"}, {31'd0, rsp_err}, {31'd0, mon_e.err});
        end
        run_len++;
        if (run_len > run_max) run_max = run_len;
      end else begin
        run_len = 0;
      end
      acc_prev = req_valid && req_ready;
    end else begin
      acc_prev = 1'b0;
      run_len  = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Store/load table (applied back-to-back)
    add("sw_10",    1'b1, SW, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
    add("lw_10",    1'b0, SW, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    add("lb_10",    1'b0, SB, 1'b0, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0);
    add("lbu_13",   1'b0, SB, 1'b1, 32'h13,  32'h0,        32'h000000DE, 1'b0);
    add("lh_12",    1'b0, SH, 1'b0, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0);
    add("lhu_10",   1'b0, SH, 1'b1, 32'h10,  32'h0,        32'h0000BEEF, 1'b0);
    add("lw_uns",   1'b0, SW, 1'b1, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    add("sw_20",    1'b1, SW, 1'b0, 32'h20,  32'h0,        32'h0,        1'b0);
    add("sb_22",    1'b1, SB, 1'b0, 32'h22,  32'h12345680, 32'h0,        1'b0);
    add("lb_22",    1'b0, SB, 1'b0, 32'h22,  32'h0,        32'hFFFFFF80, 1'b0);
    add("lbu_22",   1'b0, SB, 1'b1, 32'h22,  32'h0,        32'h00000080, 1'b0);
    // half at 0x22 is {byte 0x23 = 0x00, byte 0x22 = 0x80} = 0x0080, positive
    add("lh_22",    1'b0, SH, 1'b0, 32'h22,  32'h0,        32'h00000080, 1'b0);
    add("lw_20",    1'b0, SW, 1'b0, 32'h20,  32'h0,        32'h00800000, 1'b0);
    add("sh_26",    1'b1, SH, 1'b0, 32'h26,  32'hABCD8001, 32'h0,        1'b0);
    add("lh_26",    1'b0, SH, 1'b0, 32'h26,  32'h0,        32'hFFFF8001, 1'b0);
    add("lhu_26",   1'b0, SH, 1'b1, 32'h26,  32'h0,        32'h00008001, 1'b0);
    add("sb_25",    1'b1, SB, 1'b1, 32'h25,  32'h0000007F, 32'h0,        1'b0);
    add("lw_24",    1'b0, SW, 1'b0, 32'h24,  32'h0,        32'h80017F00, 1'b0);
    add("lb_25",    1'b0, SB, 1'b0, 32'h25,  32'h0,        32'h0000007F, 1'b0);
    add("lw_21_mis",1'b0, SW, 1'b0, 32'h21,  32'h0,        32'h0,        1'b1);
    add("sh_23_mis",1'b1, SH, 1'b0, 32'h23,  32'hFFFFFFFF, 32'h0,        1'b1);
    add("lw_20_unc",1'b0, SW, 1'b0, 32'h20,  32'h0,        32'h00800000, 1'b0);
    add("lh_21_mis",1'b0, SH, 1'b0, 32'h21,  32'h0,        32'h0,        1'b1);
    add("lx_10_ill",1'b0, SX, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1);
    add("sw_oor",   1'b1, SW, 1'b0, 32'h1000,32'h55AA55AA, 32'h0,        1'b1);
    add("lw_0",     1'b0, SW, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0);
    add("lw_oor",   1'b0, SW, 1'b0, 32'h1000,32'h0,        32'h0,        1'b1);
    add("lw_hi_oor",1'b0, SW, 1'b0, 32'h80000010, 32'h0,   32'h0,        1'b1);
    add("sw_last",  1'b1, SW, 1'b0, 32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0);
    add("lw_last",  1'b0, SW, 1'b0, 32'hFFC, 32'h0,        32'hCAFEF00D, 1'b0);
    add("lbu_fff",  1'b0, SB, 1'b1, 32'hFFF, 32'h0,        32'h000000CA, 1'b0);
    add("lb_ffe",   1'b0, SB, 1'b0, 32'hFFE, 32'h0,        32'hFFFFFFFE, 1'b0);
    add("sx_14_ill",1'b1, SX, 1'b0, 32'h14,  32'hFFFFFFFF, 32'h0,        1'b1);
    add("lw_14",    1'b0, SW, 1'b0, 32'h14,  32'h0,        32'h0,        1'b0);

    // Reset state
    idle();
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check32("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    check32("rst_rsp_rdata", rsp_rdata,          32'h0);
    check32("rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors, back-to-back
    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
            vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: response held while rsp_ready=0, queued request taken on release
    rsp_ready = 1'b0;
    issue("bp_lw_10", 1'b0, SW, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    fork
      issue("bp_lw_20", 1'b0, SW, 1'b0, 32'h20, 32'h0, 32'h00800000, 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check32("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
          check32("bp_rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
          check32("bp_rsp_rdata_hold", rsp_rdata, 32'hDEADBEEF);
          check32("bp_rsp_err_hold", {31'd0, rsp_err}, 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check32("bp_req_ready_release", {31'd0, req_ready}, 32'd1);
      end
    join
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-operation with a pending response, write attempted under reset
    rsp_ready = 1'b0;
    issue("rst_lw_20", 1'b0, SW, 1'b0, 32'h20, 32'h0, 32'h00800000, 1'b0);
    idle();
    #1;
    check32("rst_pre_valid", {31'd0, rsp_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check32("rst_async_valid", {31'd0, rsp_valid}, 32'd0);
    check32("rst_async_rdata", rsp_rdata, 32'h0);
    check32("rst_async_err",   {31'd0, rsp_err}, 32'd0);
    check32("rst_async_ready", {31'd0, req_ready}, 32'd1);
    exp_q.delete();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = SW; req_addr = 32'h10; req_wdata = 32'h12345678;
    repeat (2) @(posedge clk);
    #1 idle();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue("post_rst_lw_10", 1'b0, SW, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue("post_rst_lw_20", 1'b0, SW, 1'b0, 32'h20, 32'h0, 32'h00800000, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back throughput: 8 alternating SW/LW
    run_max = 0;
    for (int k = 0; k < 4; k++) begin
      issue("b2b_sw", 1'b1, SW, 1'b0, 32'h40 + 32'(4*k), 32'h11110000 + 32'(k), 32'h0, 1'b0);
      issue("b2b_lw", 1'b0, SW, 1'b0, 32'h40 + 32'(4*k), 32'h0, 32'h11110000 + 32'(k), 1'b0);
    end
    idle();
    repeat (4) @(posedge clk);
    #1;
    check32("b2b_consecutive_rsps", 32'(run_max), 32'd8);

    repeat (3) @(posedge clk);
    #1;
    check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
